// File: rtl/freq_disp_pkg.sv
// Shared definitions for the frequency-to-BCD display block: conversion
// FSM states and the active-low seven-segment code table.
package freq_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // All segments off on a common-anode display.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Segment codes {g,f,e,d,c,b,a}, active-low, indexed by BCD nibble.
   // Nibbles 10..15 are not decimal digits and show blank.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module bcd_to_seg7
   import freq_disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TABLE[digit];

endmodule

// File: rtl/freq_bcd_display.sv
// Converts the binary tuning frequency (kHz) to packed BCD with a
// sequential double-dabble engine and scans it onto a multiplexed,
// common-anode seven-segment display with leading-zero blanking.
// DIGITS must satisfy 10**DIGITS > 2**FREQ_SIZE - 1.
module freq_bcd_display
   import freq_disp_pkg::*;
#(
   parameter int FREQ_SIZE    = 12,
   parameter int DIGITS       = 4,
   parameter int REFRESH_SIZE = 14
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  freq_strb,
   input  logic [FREQ_SIZE-1:0]  freq,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     dig_sel_n
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SCR_W = BCD_W + FREQ_SIZE;
   localparam int CNT_W = $clog2(FREQ_SIZE + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FREQ_SIZE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t                  state;
   logic                    pending;
   logic                    load;
   logic [SCR_W-1:0]        scratch;
   logic [SCR_W-1:0]        scratch_adj;
   logic [CNT_W-1:0]        bit_cnt;

   logic [REFRESH_SIZE-1:0] scan_cnt;
   logic [IDX_W-1:0]        dig_idx;
   logic [DIGITS-1:0]       blank;
   logic                    nonzero_above;
   logic [3:0]              cur_digit;
   logic                    cur_blank;
   logic [6:0]              cur_seg;

   // A new conversion starts from IDLE or straight out of DONE; a strobe
   // arriving in DONE itself counts, so back-to-back requests never idle.
   assign load = ((state == IDLE) || (state == DONE)) && (freq_strb || pending);
   assign busy = (state != IDLE);

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[FREQ_SIZE + 4*i +: 4] >= 4'd5)
            scratch_adj[FREQ_SIZE + 4*i +: 4] = scratch[FREQ_SIZE + 4*i +: 4] + 4'd3;
      end
   end

   // Conversion control: state, request latch and the published result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         pending   <= 1'b1;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  state   <= SHIFT;
                  pending <= 1'b0;
               end
            end
            SHIFT: begin
               if (freq_strb)
                  pending <= 1'b1;
               if (bit_cnt == CNT_ONE)
                  state <= DONE;
            end
            DONE: begin
               bcd       <= scratch[SCR_W-1 -: BCD_W];
               bcd_valid <= 1'b1;
               if (load) begin
                  state   <= SHIFT;
                  pending <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scratch shift register and bit counter; freq is sampled at load time
   // so the latest value wins when requests pile up.
   always_ff @(posedge clk) begin
      if (load) begin
         scratch <= {{BCD_W{1'b0}}, freq};
         bit_cnt <= CNT_LOAD;
      end else if (state == SHIFT) begin
         scratch <= {scratch_adj[SCR_W-2:0], 1'b0};
         bit_cnt <= bit_cnt - CNT_ONE;
      end
   end

   // Free-running refresh counter; the scanned position steps on each wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         scan_cnt <= '0;
         dig_idx  <= IDX_ZERO;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (&scan_cnt)
            dig_idx <= (dig_idx == IDX_LAST) ? IDX_ZERO : dig_idx + IDX_ONE;
      end
   end

   // Leading-zero blanking, walking down from the most significant digit.
   always_comb begin
      nonzero_above = 1'b0;
      blank         = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nonzero_above = nonzero_above | (bcd[4*i +: 4] != 4'd0);
         blank[i]      = (i != 0) && !nonzero_above;
      end
   end

   // Select the scanned digit from the published result only.
   always_comb begin
      cur_digit = bcd[4*int'(dig_idx) +: 4];
      cur_blank = blank[dig_idx];
   end

   bcd_to_seg7 u_seg (
      .digit (cur_digit),
      .seg_n (cur_seg)
   );

   // Registered display drive; blanked positions turn off anode and segments.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg_n     <= SEG_BLANK;
         dig_sel_n <= '1;
      end else if (cur_blank) begin
         seg_n     <= SEG_BLANK;
         dig_sel_n <= '1;
      end else begin
         seg_n     <= cur_seg;
         dig_sel_n <= ~(DIGITS'(1) << dig_idx);
      end
   end

endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed bench for freq_bcd_display with a result scoreboard.
module tb_freq_bcd_display;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        freq_strb = 1'b0;
   logic [11:0] freq = 12'd500;

   logic        busy, bcd_valid;
   logic [15:0] bcd;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel_n;

   logic        s_busy, s_valid;
   logic [15:0] s_bcd;
   logic [6:0]  s_seg;
   logic [3:0]  s_dig;

   freq_bcd_display u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .freq_strb (freq_strb),
      .freq      (freq),
      .busy      (busy),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .seg_n     (seg_n),
      .dig_sel_n (dig_sel_n)
   );

   // Fast-scan copy so the digit rotation can be observed in a few cycles.
   freq_bcd_display #(.REFRESH_SIZE(2)) u_scan (
      .clk       (clk),
      .reset_n   (reset_n),
      .freq_strb (freq_strb),
      .freq      (freq),
      .busy      (s_busy),
      .bcd       (s_bcd),
      .bcd_valid (s_valid),
      .seg_n     (s_seg),
      .dig_sel_n (s_dig)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] sb[$];
   int          vcyc[$];
   int          busy_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int vat(input int i);
      return (i < vcyc.size()) ? vcyc[i] : -1;
   endfunction

   // Scoreboard: every bcd_valid pulse pops the oldest expected result.
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (bcd_valid) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) chk("bcd_value", 32'(bcd), 32'(sb.pop_front()));
         vcyc.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [11:0] v, output int t);
      freq      = v;
      freq_strb = 1'b1;
      @(posedge clk);
      #1;
      freq_strb = 1'b0;
      t = cyc;
   endtask

   task automatic wait_valids(input int n, input int limit, input string tag);
      int k;
      k = 0;
      while (vcyc.size() < n && k < limit) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk(tag, 32'(vcyc.size()), 32'(n));
   endtask

   // Sample 16 cycles of the fast-scan display: each shown position must
   // appear exactly 4 times with its expected code, blanks 4 times each.
   task automatic scan_window(input string tag, input logic [3:0][6:0] e, input logic [3:0] bmask);
      int hit[5];
      int bad;
      int p;
      for (int i = 0; i < 5; i++) hit[i] = 0;
      bad = 0;
      repeat (16) begin
         @(posedge clk);
         #1;
         case (s_dig)
            4'b1110: p = 0;
            4'b1101: p = 1;
            4'b1011: p = 2;
            4'b0111: p = 3;
            4'b1111: p = 4;
            default: p = -1;
         endcase
         if (p == 4) begin
            if (s_seg == 7'h7F) hit[4]++; else bad++;
         end else if (p >= 0) begin
            if (s_seg == e[p]) hit[p]++; else bad++;
         end else begin
            bad++;
         end
      end
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_pos%0d", tag, i), 32'(hit[i]), bmask[i] ? 32'd0 : 32'd4);
      chk($sformatf("%s_blank", tag), 32'(hit[4]), 32'(4 * $countones(bmask)));
      chk($sformatf("%s_bad", tag), 32'(bad), 32'd0);
   endtask

   initial begin
      int r, t, t2, t3;

      // Reset state
      tick(3);
      chk("rst_bcd", 32'(bcd), 32'h0);
      chk("rst_valid", 32'(bcd_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_seg", 32'(seg_n), 32'h7F);
      chk("rst_dig", 32'(dig_sel_n), 32'hF);

      // Automatic conversion after reset release
      sb.push_back(16'h0500);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      r = cyc;
      wait_valids(1, 30, "valid_after_reset");
      chk("latency_reset", 32'(vat(0)), 32'(r + 13));
      tick(2);
      scan_window("disp500", {7'h7F, 7'h12, 7'h40, 7'h40}, 4'b1000);

      // Single strobe, latency and busy width
      tick(2);
      busy_cnt = 0;
      sb.push_back(16'h1700);
      strobe(12'd1700, t);
      wait_valids(2, 30, "valid_1700");
      chk("latency_1700", 32'(vat(1)), 32'(t + 13));
      tick(3);
      chk("busy_cycles", 32'(busy_cnt), 32'd13);

      // Maximum value, then zero
      sb.push_back(16'h4095);
      strobe(12'd4095, t);
      wait_valids(3, 30, "valid_4095");
      tick(2);
      sb.push_back(16'h0000);
      strobe(12'd0, t);
      wait_valids(4, 30, "valid_0");
      tick(2);
      chk("zero_seg_main", 32'(seg_n), 32'h40);
      chk("zero_dig_main", 32'(dig_sel_n), 32'hE);
      scan_window("disp0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110);

      // Three strobes during one conversion collapse into one reload
      tick(2);
      sb.push_back(16'h0510);
      sb.push_back(16'h0530);
      strobe(12'd510, t);
      tick(2);
      strobe(12'd520, t2);
      tick(2);
      strobe(12'd530, t3);
      wait_valids(6, 50, "valid_multi");
      chk("latency_multi", 32'(vat(4)), 32'(t + 13));
      chk("b2b_spacing", 32'(vat(5) - vat(4)), 32'd13);
      tick(5);
      chk("multi_pulses", 32'(vcyc.size()), 32'd6);

      // Strobe landing in the DONE cycle restarts immediately
      sb.push_back(16'h0100);
      sb.push_back(16'h0200);
      strobe(12'd100, t);
      tick(12);
      freq      = 12'd200;
      freq_strb = 1'b1;
      @(posedge clk);
      #1;
      freq_strb = 1'b0;
      wait_valids(8, 40, "valid_done_strb");
      chk("latency_done1", 32'(vat(6)), 32'(t + 13));
      chk("latency_done2", 32'(vat(7)), 32'(t + 26));

      // Reset during SHIFT aborts, then a fresh conversion follows release
      tick(2);
      strobe(12'd1234, t);
      tick(5);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_bcd", 32'(bcd), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_valid", 32'(bcd_valid), 32'h0);
      chk("midrst_seg", 32'(seg_n), 32'h7F);
      chk("midrst_dig", 32'(dig_sel_n), 32'hF);
      tick(1);
      sb.push_back(16'h1234);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      r = cyc;
      wait_valids(9, 40, "valid_after_midrst");
      chk("latency_midrst", 32'(vat(8)), 32'(r + 13));

      tick(20);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("total_pulses", 32'(vcyc.size()), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
